seg7_mux_driver: RTL



---
 rtl/seg7_mux_driver.sv | 98 +++++++++
 1 files changed

// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: time-multiplexed, double-buffered hex driver for an N-digit common-anode 7-segment display
//   clk, rst_n          : clock, asynchronous active-low reset
//   value, dp_in        : nibble k / dp bit k feed digit k, captured into the shadow on load
//   digit_en, lz_en     : live per-digit enable and leading-zero suppression
//   load                : capture strobe; the shadow commits to the display at the next frame boundary
//   an, seg, dp         : active-low anodes, segments {g,f,e,d,c,b,a}, decimal point (registered)
//   frame_done          : one-cycle pulse after each frame boundary
module seg7_mux_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int GHOST_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_v_q, sh_v_d, disp_v_q, disp_v_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
  logic                    pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d, fd_q;
  logic                    slot_end, boundary, vis, zero_run;
  logic [NUM_DIGITS-1:0]   sup;
  logic [3:0]              nib;
  always_comb begin
    slot_end  = presc_q == PW'(REFRESH_DIV - 1);
    boundary  = slot_end && idx_q == IW'(NUM_DIGITS - 1);
    presc_d   = slot_end ? '0 : presc_q + 1'b1;
    idx_d     = boundary ? '0 : slot_end ? idx_q + 1'b1 : idx_q;
    sh_v_d    = load ? value : sh_v_q;
    sh_dp_d   = load ? dp_in : sh_dp_q;
    // a load landing on the boundary edge bypasses the shadow and commits directly
    disp_v_d  = boundary && load ? value : boundary && pend_q ? sh_v_q : disp_v_q;
    disp_dp_d = boundary && load ? dp_in : boundary && pend_q ? sh_dp_q : disp_dp_q;
    pend_d    = boundary ? 1'b0 : load | pend_q;
    // a digit is suppressed when it and every more significant nibble are zero
    sup      = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (disp_v_q[4*k +: 4] == 4'd0);
      sup[k]   = lz_en & zero_run & (k != 0);
    end
    nib         = disp_v_q[idx_q*4 +: 4];
    vis         = digit_en[idx_q] & ~sup[idx_q] & (int'(presc_q) >= GHOST_CYCLES);
    an_d        = '1;
    an_d[idx_q] = ~vis;
    seg_d       = vis ? SEG_LUT[nib] : 7'h7F;
    dp_d        = vis ? ~disp_dp_q[idx_q] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      sh_v_q    <= '0;
      sh_dp_q   <= '0;
      disp_v_q  <= '0;
      disp_dp_q <= '0;
      pend_q    <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      sh_v_q    <= sh_v_d;
      sh_dp_q   <= sh_dp_d;
      disp_v_q  <= disp_v_d;
      disp_dp_q <= disp_dp_d;
      pend_q    <= pend_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      fd_q      <= boundary;
    end
  end
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;
endmodule
